systolic_matmul_engine: RTL

//  Output-stationary ROWS x COLS signed-integer systolic matrix-multiply engine with its own control.

---
 rtl/systolic_matmul_engine_pkg.sv | 15 +
 rtl/systolic_matmul_engine_if.sv | 19 +
 rtl/systolic_matmul_engine_pe.sv | 33 +++
 rtl/systolic_matmul_engine.sv | 120 ++++++++++++
 4 files changed

// File: rtl/systolic_matmul_engine_pkg.sv
// systolic_pkg: FSM state type and the shared multiply-accumulate step
package systolic_pkg;
    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

    // Returns {acc_next, ovf}; acc is sign-extended to 64 bits, acc_w <= 63.
    function automatic logic [64:0] mac_step(input logic signed [63:0] acc, input logic signed [31:0] a,
                                             input logic signed [31:0] b, input int acc_w, input logic sat);
        logic signed [63:0] s, hi, lo, w;
        s = acc + 64'(a) * 64'(b);
        hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        w = (s <<< (64 - acc_w)) >>> (64 - acc_w);
        return {sat ? (s > hi ? hi : (s < lo ? lo : s)) : w, s > hi || s < lo};
    endfunction
endpackage

// File: rtl/systolic_matmul_engine_if.sv
// systolic_matmul_engine_if: job control, operand stream and result stream
interface systolic_matmul_engine_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W = 32,
    parameter int K_MAX = 256
);
    logic start, busy, in_valid, in_ready, out_valid, out_ready, out_last, done, ovf;
    logic [$clog2(K_MAX+1)-1:0] k_len;
    logic [ROWS*DATA_W-1:0] a_vec;
    logic [COLS*DATA_W-1:0] b_vec;
    logic [COLS*ACC_W-1:0] out_row;
    logic [$clog2(ROWS)-1:0] out_idx;
    modport master (output start, k_len, in_valid, a_vec, b_vec, out_ready,
                    input busy, in_ready, out_valid, out_row, out_idx, out_last, done, ovf);
    modport slave (input start, k_len, in_valid, a_vec, b_vec, out_ready,
                   output busy, in_ready, out_valid, out_row, out_idx, out_last, done, ovf);
endinterface

// File: rtl/systolic_matmul_engine_pe.sv
// systolic_pe: output-stationary MAC cell with registered A/B pass-through
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W = 32,
    parameter int SATURATE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic adv_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic [ACC_W-1:0] acc_o,
    output logic ovf_o
);
    logic [DATA_W-1:0] a_q, b_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic ovf_q, ovf_d;
    logic [64:0] m;
    assign m = mac_step(64'(signed'(acc_q)), 32'(signed'(a_i)), 32'(signed'(b_i)), ACC_W, SATURATE != 0);
    assign acc_d = m[ACC_W:1];
    // the bits above ACC_W must be pure sign extension of an in-range result
    assign ovf_d = ovf_q | m[0] | (m[64:ACC_W+1] != {(64-ACC_W){m[ACC_W]}});
    always_ff @(posedge clk or posedge rst)
        if (rst) {a_q, b_q, acc_q, ovf_q} <= '0;
        else if (clr_i) {a_q, b_q, acc_q, ovf_q} <= '0;
        else if (adv_i) {a_q, b_q, acc_q, ovf_q} <= {a_i, b_i, acc_d, ovf_d};
    assign {a_o, b_o, acc_o, ovf_o} = {a_q, b_q, acc_q, ovf_q};
endmodule

// File: rtl/systolic_matmul_engine.sv
// systolic_matmul_engine: ROWS x COLS output-stationary systolic matmul with skew, FSM and row drain
module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W = 32,
    parameter int K_MAX = 256,
    parameter int SATURATE = 0
) (
    input logic clk,
    input logic rst,
    systolic_matmul_engine_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int FL = ROWS + COLS - 2;
    localparam int FW = $clog2(FL + 1);
    localparam int RW = $clog2(ROWS);
    state_t st_q, st_d;
    logic [KW-1:0] k_q, k_d, beat_q, beat_d;
    logic [FW-1:0] fl_q, fl_d;
    logic [RW-1:0] row_q, row_d;
    logic done_q, done_d, adv, clr;
    logic [DATA_W-1:0] a_h [ROWS][COLS+1];
    logic [DATA_W-1:0] b_v [ROWS+1][COLS];
    logic [ACC_W-1:0] acc [ROWS][COLS];
    logic [ROWS*COLS-1:0] pe_ovf;
    assign adv = (st_q == FEED && bus.in_valid) || st_q == FLUSH;
    assign clr = st_q == IDLE && bus.start && bus.k_len != '0;
    always_comb begin
        st_d = st_q;
        k_d = k_q;
        beat_d = beat_q;
        fl_d = fl_q;
        row_d = row_q;
        done_d = 1'b0;
        case (st_q)
            IDLE: begin
                done_d = bus.start && bus.k_len == '0;
                if (clr) begin
                    st_d = FEED;
                    k_d = bus.k_len > KW'(K_MAX) ? KW'(K_MAX) : bus.k_len;
                    {beat_d, fl_d, row_d} = '0;
                end
            end
            FEED: if (bus.in_valid) begin
                beat_d = beat_q + 1'b1;
                st_d = beat_q == k_q - 1'b1 ? FLUSH : FEED;
            end
            FLUSH: begin
                fl_d = fl_q + 1'b1;
                st_d = fl_q == FW'(FL - 1) ? DRAIN : FLUSH;
            end
            DRAIN: if (bus.out_ready) begin
                done_d = row_q == RW'(ROWS - 1);
                row_d = done_d ? '0 : row_q + 1'b1;
                st_d = done_d ? IDLE : DRAIN;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) {st_q, k_q, beat_q, fl_q, row_q, done_q} <= {IDLE, KW'(0), KW'(0), FW'(0), RW'(0), 1'b0};
        else {st_q, k_q, beat_q, fl_q, row_q, done_q} <= {st_d, k_d, beat_d, fl_d, row_d, done_d};
    // lane r of A waits r advances so PE(r,c) sees pair k at advance k+r+c
    for (genvar r = 0; r < ROWS; r++) begin : g_ask
        logic [DATA_W-1:0] a_in;
        assign a_in = st_q == FEED ? bus.a_vec[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_z
            assign a_h[r][0] = a_in;
        end else begin : g_sr
            logic [DATA_W-1:0] sr_q [r];
            always_ff @(posedge clk or posedge rst)
                if (rst) for (int i = 0; i < r; i++) sr_q[i] <= '0;
                else if (clr) for (int i = 0; i < r; i++) sr_q[i] <= '0;
                else if (adv) begin
                    sr_q[0] <= a_in;
                    for (int i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
                end
            assign a_h[r][0] = sr_q[r-1];
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_bsk
        logic [DATA_W-1:0] b_in;
        assign b_in = st_q == FEED ? bus.b_vec[c*DATA_W +: DATA_W] : '0;
        if (c == 0) begin : g_z
            assign b_v[0][c] = b_in;
        end else begin : g_sr
            logic [DATA_W-1:0] sr_q [c];
            always_ff @(posedge clk or posedge rst)
                if (rst) for (int i = 0; i < c; i++) sr_q[i] <= '0;
                else if (clr) for (int i = 0; i < c; i++) sr_q[i] <= '0;
                else if (adv) begin
                    sr_q[0] <= b_in;
                    for (int i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
                end
            assign b_v[0][c] = sr_q[c-1];
        end
    end
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            systolic_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W), .SATURATE(SATURATE)) u_pe (
                .clk(clk), .rst(rst), .clr_i(clr), .adv_i(adv),
                .a_i(a_h[r][c]), .b_i(b_v[r][c]), .a_o(a_h[r][c+1]), .b_o(b_v[r+1][c]),
                .acc_o(acc[r][c]), .ovf_o(pe_ovf[r*COLS+c])
            );
        end
    end
    for (genvar c = 0; c < COLS; c++) begin : g_mux
        assign bus.out_row[c*ACC_W +: ACC_W] = acc[row_q][c];
    end
    assign bus.busy = st_q != IDLE;
    assign bus.in_ready = st_q == FEED;
    assign bus.out_valid = st_q == DRAIN;
    assign bus.out_idx = row_q;
    assign bus.out_last = st_q == DRAIN && row_q == RW'(ROWS - 1);
    assign bus.done = done_q;
    assign bus.ovf = |pe_ovf;
endmodule
